// File: rtl/fifo_serial_tx_if.sv
// FIFO read-port bundle between the lab FIFO and its serial drain consumer.
interface fifo_serial_tx_if #(
  parameter int unsigned WIDTH = 9
);
  logic             FifoEmpty;
  logic [WIDTH-1:0] FifoData;
  logic             ReadN;

  // Consumer side: issues the active-low read strobe and receives data/empty.
  modport master (
    input  FifoEmpty,
    input  FifoData,
    output ReadN
  );

  // FIFO side: supplies data/empty and reacts to the read strobe.
  modport slave (
    output FifoEmpty,
    output FifoData,
    input  ReadN
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// FIFO drain to asynchronous serial line: start bit, WIDTH data bits LSB-first,
// stop bit. One FIFO pop per frame, frame counter for the 7-segment display.
module fifo_serial_tx #(
  parameter int unsigned WIDTH        = 9,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  fifo_serial_tx_if.master        Fifo,
  output logic                    TxOut,
  output logic                    Busy,
  output logic [3:0]              FrameCount
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [15:0]   LAST_BAUD = 16'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [15:0]      baud, baud_nxt;
  logic [IW-1:0]    bit_idx, bit_idx_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic             read_n, read_n_nxt;
  logic             tx, tx_nxt;
  logic             busy, busy_nxt;
  logic [3:0]       frames, frames_nxt;
  logic             bit_end;

  assign bit_end    = (baud == LAST_BAUD);
  assign Fifo.ReadN = read_n;
  assign TxOut      = tx;
  assign Busy       = busy;
  assign FrameCount = frames;

  // State and registered outputs; reset forces the line high immediately.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      read_n  <= 1'b1;
      tx      <= 1'b1;
      busy    <= 1'b0;
      frames  <= '0;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      read_n  <= read_n_nxt;
      tx      <= tx_nxt;
      busy    <= busy_nxt;
      frames  <= frames_nxt;
    end
  end

  // Next-state and next-output values; outputs are computed one cycle ahead
  // so every port comes straight from a flop.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    read_n_nxt  = 1'b1;
    tx_nxt      = tx;
    frames_nxt  = frames;
    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        baud_nxt = '0;
        if (Enable && !Fifo.FifoEmpty) begin
          state_nxt  = FETCH;
          read_n_nxt = 1'b0;
        end
      end
      FETCH: begin
        // FIFO popped on the falling edge inside this cycle; data is valid now.
        shift_nxt = Fifo.FifoData;
        tx_nxt    = 1'b0;
        baud_nxt  = '0;
        state_nxt = START;
      end
      START: begin
        if (bit_end) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          tx_nxt      = shift[0];
          state_nxt   = DATA;
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          if (bit_idx == LAST_IDX) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
            tx_nxt      = shift_nxt[0];
          end
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          baud_nxt   = '0;
          frames_nxt = frames + 4'd1;
          state_nxt  = IDLE;
        end else begin
          baud_nxt = baud + 16'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        baud_nxt  = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench for fifo_serial_tx with a behavioural FIFO that pops on the
// falling edge while ReadN is low.
module tb_fifo_serial_tx;

  localparam int unsigned W   = 9;
  localparam int unsigned CPB = 4;

  logic       Clock  = 1'b0;
  logic       Reset  = 1'b0;
  logic       Enable = 1'b0;
  logic       TxOut;
  logic       Busy;
  logic [3:0] FrameCount;

  fifo_serial_tx_if #(.WIDTH(W)) bus ();

  fifo_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .Fifo       (bus.master),
    .TxOut      (TxOut),
    .Busy       (Busy),
    .FrameCount (FrameCount)
  );

  always #5 Clock = ~Clock;

  // Behavioural FIFO and line monitor.
  logic [W-1:0] mem [0:255];
  int unsigned  wr_ptr     = 0;
  int unsigned  rd_ptr     = 0;
  logic [W-1:0] fifo_data  = '0;
  logic         flush      = 1'b0;
  int unsigned  readn_lows = 0;
  int unsigned  hi_run     = 0;
  int unsigned  last_gap   = 0;

  assign bus.FifoEmpty = (wr_ptr == rd_ptr);
  assign bus.FifoData  = fifo_data;

  always @(negedge Clock) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.ReadN === 1'b0) begin
      readn_lows <= readn_lows + 1;
      if (wr_ptr != rd_ptr) begin
        fifo_data <= mem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
    if (TxOut === 1'b1) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  int unsigned fetch_cyc = 0;
  int unsigned frame_gap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [W-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    Reset = 1'b1;
    tick();
  endtask

  // Wait for the fetch strobe, then check one full frame cycle by cycle.
  task automatic run_frame(input logic [W-1:0] exp, input string tag, input bit drop_en);
    bit           found;
    int           bad;
    logic [W-1:0] word;
    logic [10:0]  frame_bits;
    frame_bits = {1'b1, exp, 1'b0};
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.ReadN === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, " fetch"}, 32'(found), 32'd1);
    if (!found) return;
    fetch_cyc = cyc;
    check({tag, " busy_at_fetch"}, 32'(Busy), 32'd1);
    tick();
    if (drop_en) Enable = 1'b0;
    check({tag, " readn_one_cycle"}, 32'(bus.ReadN), 32'd1);
    check({tag, " start_edge"}, 32'(TxOut), 32'd0);
    bad  = 0;
    word = '0;
    for (int c = 0; c < 44; c++) begin
      if (c > 0) tick();
      if (c == 1) frame_gap = last_gap;
      if (TxOut !== frame_bits[c / 4]) bad++;
      if (c % 4 == 2 && c >= 4 && c < 40) word[c / 4 - 1] = TxOut;
    end
    check({tag, " line_bad_cycles"}, 32'(bad), 32'd0);
    check({tag, " word"}, 32'(word), 32'(exp));
    tick();
    check({tag, " busy_end"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    int unsigned base;
    int unsigned f1;
    int unsigned f2;
    bit          found;

    // Reset held.
    tick();
    tick();
    check("rst txout", 32'(TxOut), 32'd1);
    check("rst readn", 32'(bus.ReadN), 32'd1);
    check("rst busy", 32'(Busy), 32'd0);
    check("rst framecount", 32'(FrameCount), 32'd0);
    Reset = 1'b1;
    tick();

    // Single frame 9'h1A5.
    push(9'h1A5);
    Enable = 1'b1;
    run_frame(9'h1A5, "single", 1'b0);
    check("single framecount", 32'(FrameCount), 32'd1);

    // Back-to-back frames.
    Enable = 1'b0;
    do_reset();
    push(9'h000);
    push(9'h1FF);
    push(9'h0AA);
    base = readn_lows;
    Enable = 1'b1;
    run_frame(9'h000, "b2b0", 1'b0);
    f1 = fetch_cyc;
    run_frame(9'h1FF, "b2b1", 1'b0);
    f2 = fetch_cyc;
    check("b2b gap_high", 32'(frame_gap), 32'd6);
    check("b2b spacing01", 32'(f2 - f1), 32'd46);
    run_frame(9'h0AA, "b2b2", 1'b0);
    check("b2b spacing12", 32'(fetch_cyc - f2), 32'd46);
    repeat (100) tick();
    check("b2b framecount", 32'(FrameCount), 32'd3);
    check("b2b readn_pulses", 32'(readn_lows - base), 32'd3);

    // Enable gating.
    Enable = 1'b0;
    do_reset();
    push(9'h033);
    push(9'h1C7);
    base = readn_lows;
    repeat (200) tick();
    check("gate idle_readn", 32'(readn_lows - base), 32'd0);
    check("gate idle_busy", 32'(Busy), 32'd0);
    Enable = 1'b1;
    run_frame(9'h033, "gate", 1'b1);
    repeat (200) tick();
    check("gate readn_pulses", 32'(readn_lows - base), 32'd1);
    check("gate framecount", 32'(FrameCount), 32'd1);
    check("gate word_left", 32'(bus.FifoEmpty), 32'd0);

    // Reset pulse mid-DATA while the line is low (bit 3 of 9'h155).
    Enable = 1'b0;
    do_reset();
    push(9'h155);
    Enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.ReadN === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("midrst fetch", 32'(found), 32'd1);
    tick();
    repeat (18) tick();
    check("midrst bit3", 32'(TxOut), 32'd0);
    #2 Reset = 1'b0;
    #1;
    check("midrst txout", 32'(TxOut), 32'd1);
    check("midrst busy", 32'(Busy), 32'd0);
    check("midrst readn", 32'(bus.ReadN), 32'd1);
    Enable = 1'b0;
    tick();
    Reset = 1'b1;
    tick();

    // Reset recovery: reset during bit 4 of 9'h155, then 9'h0F0 follows.
    push(9'h155);
    Enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.ReadN === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("recov fetch", 32'(found), 32'd1);
    tick();
    repeat (21) tick();
    check("recov bit4", 32'(TxOut), 32'd1);
    check("recov busy_before", 32'(Busy), 32'd1);
    #2 Reset = 1'b0;
    push(9'h0F0);
    tick();
    tick();
    Reset = 1'b1;
    run_frame(9'h0F0, "recov", 1'b0);
    check("recov framecount", 32'(FrameCount), 32'd1);

    // Frame counter wrap over 17 frames.
    Enable = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) push(W'(i * 37 + 5));
    Enable = 1'b1;
    for (int i = 0; i < 17; i++) begin
      run_frame(W'(i * 37 + 5), "wrap", 1'b0);
      if (i == 14) check("wrap fc15", 32'(FrameCount), 32'd15);
      if (i == 15) check("wrap fc0", 32'(FrameCount), 32'd0);
      if (i == 16) check("wrap fc1", 32'(FrameCount), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Drain-side consumer for the lab FIFO. When enabled, it pops one word at a time through the FIFO's active-low read strobe and shifts each word out on a single asynchronous serial line. The frame is one start bit, WIDTH data bits LSB-first, and one stop bit. It sits between the FIFO read port and a GPIO/UART pin, and exposes a frame counter for the 7-segment display.

## Interface
Parameters:
- WIDTH, 9: data word width; matches the FIFO word width.
- CLKS_PER_BIT, 434: Clock cycles per serial bit. Legal range 2..65535 (16-bit baud counter).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  reset Reset, asynchronous, active-low.
- Enable  in  1  1 = drain FIFO automatically. Sampled only in IDLE.
- FifoEmpty  in  1  FIFO empty flag.
- FifoData  in  WIDTH  FIFO registered read data.
- ReadN  out  1  active-low read strobe to FIFO. Registered; low for exactly one cycle per frame.
- TxOut  out  1  serial line; idles high.
- Busy  out  1  1 whenever state is not IDLE.
- FrameCount  out  4  completed frames, modulo 16.

## Operation
- Reset values: state IDLE, ReadN=1, TxOut=1, Busy=0, FrameCount=0. Baud counter, bit index and shift register are all 0.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE: TxOut=1.
  - If Enable=1 and FifoEmpty=0 at a rising edge, go to FETCH and drive ReadN=0.
  - Otherwise remain in IDLE.
- FETCH: lasts exactly one cycle with ReadN=0.
  - The FIFO pops on the falling edge inside this cycle.
  - At the next rising edge: load FifoData into the shift register, set ReadN=1, TxOut=0, and go to START.
- START: TxOut=0 for CLKS_PER_BIT cycles, then go to DATA with TxOut=shift[0] and bit index 0.
- DATA: each bit is held for CLKS_PER_BIT cycles.
  - After each bit, shift right and increment the bit index.
  - After bit index WIDTH-1 completes, go to STOP with TxOut=1.
- STOP: TxOut=1 for CLKS_PER_BIT cycles.
  - At the end, increment FrameCount (wraps 15 -> 0) and go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, resets to 0 on every bit boundary, and is held at 0 in IDLE and FETCH.
- Enable is ignored outside IDLE. Deasserting Enable mid-frame lets the current frame finish; no further fetch follows.
- FifoEmpty is ignored outside IDLE. A word is never fetched while FifoEmpty=1.
- ReadN is never low in any state other than FETCH.
- Reset asserted in any state forces the reset values immediately (TxOut high in the same instant). The in-flight word is discarded, not re-read.

## Timing
- Fetch latency: rising edge E0 in IDLE with non-empty FIFO -> ReadN low during cycle E0..E1 -> TxOut falls at E1.
- Frame length on the line: (WIDTH+2)*CLKS_PER_BIT cycles, from the TxOut fall at E1 to the end of STOP.
- Busy rises at E0 and falls at the edge that ends STOP. FrameCount updates on that same edge.
- Back-to-back frames: the line stays high for CLKS_PER_BIT+2 cycles between frames (STOP + IDLE + FETCH).
- Consecutive ReadN pulses are therefore (WIDTH+2)*CLKS_PER_BIT+2 cycles apart.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=9, CLKS_PER_BIT=4, with a behavioural FIFO model that samples ReadN on the falling edge.
- Reset check: hold Reset=0 -> TxOut=1, ReadN=1, Busy=0, FrameCount=0. Pulse Reset low mid-DATA -> TxOut=1 and Busy=0 immediately.
- Single frame: preload 9'h1A5, Enable=1.
  - ReadN low exactly 1 cycle.
  - TxOut: 0 for 4 cycles; then 1,0,1,0,0,1,0,1,1, each for 4 cycles; then 1 for 4 cycles (44 cycles total).
  - Afterwards FrameCount=1, Busy=0.
- Back-to-back: preload 9'h000, 9'h1FF, 9'h0AA -> three ReadN pulses 46 cycles apart and 6 high cycles between frames.
  - Line data matches LSB-first for each word.
  - FrameCount=3, and no fourth ReadN once FifoEmpty=1.
- Enable gating:
  - Enable=0 with 2 words queued -> no ReadN for 200 cycles.
  - Enable=1 then 0 during START of frame 1 -> frame 1 completes, frame 2 is never fetched.
- Reset recovery: assert Reset during bit 4 of word 9'h155, release, keep Enable=1 with 9'h0F0 queued -> next frame carries 9'h0F0 and FrameCount=1.
- Counter wrap: send 17 frames -> FrameCount reads 15 after the 15th frame, then 0, then 1.
